// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// seg_pkg
// Shared definitions for the multiplexed 7-segment display driver:
// active-low glyph constants (bit7 = dp, bits6..0 = g..a), the blank
// pattern, and the scroll-buffer slot type.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal digits, active-low, dp off.
  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;

  // Hex letters, only shown when the decoder is built with HEX_EN=1.
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // One scroll-buffer entry: valid marks an occupied slot.
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } slot_t;

endpackage

// File: rtl/seg_scan_display_decode.sv
`timescale 1ns/1ps
// seg_digit_decode
// Combinational 4-bit code to active-low 7-segment pattern.
// Ports:
//   valid - slot occupied; an empty slot is blanked
//   code  - symbol code 0..F
//   seg   - active-low pattern, bit7 = dp (always off)
// Parameter HEX_EN selects whether A..F show letters or stay blank.
module seg_digit_decode
  import seg_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic       valid,
  input  logic [3:0] code,
  output logic [7:0] seg
);

  localparam bit SHOW_HEX = (HEX_EN != 0);

  // NOTE: seg gets a default before the case so every path assigns it;
  // a missing assignment in combinational logic would infer a latch.
  always_comb begin
    seg = SEG_BLANK;
    if (valid) begin
      case (code)
        4'h0: seg = GLYPH_0;
        4'h1: seg = GLYPH_1;
        4'h2: seg = GLYPH_2;
        4'h3: seg = GLYPH_3;
        4'h4: seg = GLYPH_4;
        4'h5: seg = GLYPH_5;
        4'h6: seg = GLYPH_6;
        4'h7: seg = GLYPH_7;
        4'h8: seg = GLYPH_8;
        4'h9: seg = GLYPH_9;
        4'hA: seg = SHOW_HEX ? GLYPH_A : SEG_BLANK;
        4'hB: seg = SHOW_HEX ? GLYPH_B : SEG_BLANK;
        4'hC: seg = SHOW_HEX ? GLYPH_C : SEG_BLANK;
        4'hD: seg = SHOW_HEX ? GLYPH_D : SEG_BLANK;
        4'hE: seg = SHOW_HEX ? GLYPH_E : SEG_BLANK;
        default: seg = SHOW_HEX ? GLYPH_F : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
`timescale 1ns/1ps
// seg_scan_display
// Multi-digit time-multiplexed 7-segment driver. Each rising edge of the
// asynchronous strobe `flag` pushes `key` into digit 0 of a scrolling
// buffer (older symbols move up, the oldest falls off when full). The
// buffer is scanned one digit at a time onto a shared segment bus.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   key       - symbol code, captured on the detected flag edge
//   flag      - asynchronous push strobe (rising edge used)
//   clr       - synchronous buffer clear, wins over a same-cycle push
//   seg_out   - active-low segments, bit7 = dp (held 1)
//   an_out    - active-low one-hot digit enables
//   fill_cnt  - number of valid slots, saturates at N_DIGITS
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int HEX_EN   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    key,
  input  logic                          flag,
  input  logic                          clr,
  output logic [7:0]                    seg_out,
  output logic [N_DIGITS-1:0]           an_out,
  output logic [$clog2(N_DIGITS+1)-1:0] fill_cnt
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

  // Strobe path: two synchroniser flops, then the edge register pair.
  logic sync_1, sync_2, sync_q, prev_q;
  logic push;

  slot_t             slots [N_DIGITS];
  logic [IDX_W-1:0]  idx;
  logic [DIV_W-1:0]  div;
  logic [7:0]        dec_seg;
  slot_t             cur_slot;

  assign push     = sync_q & ~prev_q;
  assign cur_slot = slots[idx];

  seg_digit_decode #(.HEX_EN(HEX_EN)) u_decode (
    .valid (cur_slot.valid),
    .code  (cur_slot.code),
    .seg   (dec_seg)
  );

  // NOTE: all state updates here use non-blocking assignments so every
  // flop samples pre-edge values; the buffer shift relies on this.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      fill_cnt <= '0;
      idx      <= '0;
      div      <= '0;
      seg_out  <= SEG_BLANK;
      an_out   <= '1;
      // NOTE: only the valid bits are reset; slot codes are never shown
      // unless valid, so leaving them unreset keeps the buffer plain RAM-like
      // storage with an enable.
      for (int i = 0; i < N_DIGITS; i++) slots[i].valid <= 1'b0;
    end else begin
      sync_1 <= flag;
      sync_2 <= sync_1;
      sync_q <= sync_2;
      prev_q <= sync_q;

      if (clr) begin
        for (int i = 0; i < N_DIGITS; i++) slots[i].valid <= 1'b0;
        fill_cnt <= '0;
      end else if (push) begin
        for (int i = N_DIGITS - 1; i > 0; i--) slots[i] <= slots[i-1];
        slots[0] <= '{valid: 1'b1, code: key};
        if (fill_cnt != CNT_FULL) fill_cnt <= fill_cnt + 1'b1;
      end

      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end

      // Outputs follow the scan index by one cycle and read the live
      // buffer, so a push shows up without waiting for a scan step.
      an_out  <= ~(AN_ONE << idx);
      seg_out <= dec_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
`timescale 1ns/1ps
// Bench for seg_scan_display with N_DIGITS=4, SCAN_DIV=4. Two instances
// share all inputs: dut0 with HEX_EN=0 and dut1 with HEX_EN=1.
module tb_seg_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       flag;
  logic       clr;
  logic [7:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic [2:0] fill0, fill1;

  always #5 clk = ~clk;

  seg_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(0)) dut0 (
    .clk(clk), .rst(rst), .key(key), .flag(flag), .clr(clr),
    .seg_out(seg0), .an_out(an0), .fill_cnt(fill0)
  );

  seg_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(1)) dut1 (
    .clk(clk), .rst(rst), .key(key), .flag(flag), .clr(clr),
    .seg_out(seg1), .an_out(an1), .fill_cnt(fill1)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference buffer model: index 0 is the newest symbol.
  logic       mv [4];
  logic [3:0] mc [4];
  int         mfill;

  function automatic logic [7:0] exp_glyph(input logic v, input logic [3:0] c,
                                           input bit hex);
    logic [7:0] g;
    if (!v) return 8'hFF;
    case (c)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    if (!hex && c > 4'h9) g = 8'hFF;
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    mfill = 0;
  endtask

  task automatic model_push(input logic [3:0] k);
    for (int i = 3; i > 0; i--) begin
      mv[i] = mv[i-1];
      mc[i] = mc[i-1];
    end
    mv[0] = 1'b1;
    mc[0] = k;
    if (mfill < 4) mfill++;
  endtask

  task automatic push_key(input logic [3:0] k, input int width);
    key  = k;
    flag = 1'b1;
    step(width);
    flag = 1'b0;
    step(6);
    model_push(k);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    model_clear();
  endtask

  // Queue the expected pattern of every digit, then pop each one as the
  // scan reaches that digit's enable.
  task automatic check_digits(input string tag, input bit hex);
    exp_t e;
    int   budget;
    for (int d = 0; d < 4; d++)
      exp_q.push_back('{an: ~(4'b0001 << d), seg: exp_glyph(mv[d], mc[d], hex)});
    budget = 64;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if ((hex ? an1 : an0) === exp_q[0].an) begin
        e = exp_q.pop_front();
        check($sformatf("%s an=%h seg", tag, e.an), hex ? seg1 : seg0, e.seg);
      end
    end
    if (exp_q.size() > 0) begin
      check($sformatf("%s scan timeout", tag), exp_q.size(), 0);
      exp_q.delete();
    end
    check($sformatf("%s fill", tag), hex ? fill1 : fill0, mfill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst  = 1'b1;
    key  = 4'h0;
    flag = 1'b0;
    clr  = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) mc[i] = 4'h0;

    // 1. Reset values, then an idle scan of 32 cycles.
    step(3);
    check("reset seg", seg0, 8'hFF);
    check("reset an", an0, 4'hF);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check($sformatf("idle cyc%0d an/seg", k), {an0, seg0},
            {~(4'b0001 << (((k - 1) / 4) % 4)), 8'hFF});
    end
    check("idle fill", fill0, 0);

    // 2. Two pushes.
    push_key(4'h3, 10);
    push_key(4'h7, 10);
    check_digits("two_push", 1'b0);

    // 3. Overfill: oldest symbol drops out.
    do_clr();
    for (int k = 1; k <= 5; k++) push_key(4'(k), 10);
    check_digits("overfill", 1'b0);

    // 4. Hex code: blank without HEX_EN, letter with it.
    do_clr();
    push_key(4'hA, 10);
    check_digits("hex_off", 1'b0);
    check_digits("hex_on", 1'b1);

    // 5a. A long level gives exactly one push.
    do_clr();
    push_key(4'h6, 50);
    check_digits("held_flag", 1'b0);

    // 5b. clr landing on the push cycle drops the symbol.
    key  = 4'h9;
    flag = 1'b1;
    step(3);
    clr = 1'b1;
    step(1);
    clr  = 1'b0;
    flag = 1'b0;
    step(6);
    model_clear();
    check_digits("clr_vs_push", 1'b0);

    // 6. Reset mid-scan at idx=2 with three valid slots.
    push_key(4'h1, 10);
    push_key(4'h2, 10);
    push_key(4'h3, 10);
    check_digits("pre_reset", 1'b0);
    budget = 32;
    while (an0 !== 4'hB && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait idx2", an0, 4'hB);
    rst = 1'b1;
    step(1);
    check("mid reset seg", seg0, 8'hFF);
    check("mid reset an", an0, 4'hF);
    check("mid reset fill", fill0, 0);
    rst = 1'b0;
    model_clear();
    step(1);
    check("restart an", an0, 4'hE);
    check("restart seg", seg0, 8'hFF);
    check_digits("post_reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Multi-digit, time-multiplexed 7-segment driver and successor to the single-digit latch-on-strobe display.
- Each rising edge of `flag` pushes one 4-bit decoded symbol into an N-digit scrolling buffer; the newest symbol sits in digit 0 and older symbols shift left.
- The buffer is scanned one digit at a time onto a shared active-low segment bus with per-digit active-low enables.
- Sits between the Morse decoder's symbol output and the board's multiplexed display.

Parameters:
- N_DIGITS, 4: number of buffer slots and anode lines; legal range 1..8.
- SCAN_DIV, 1000: clk cycles each digit is held before the scan advances; must be >=1.
- HEX_EN, 0: 1 shows 4'hA..4'hF as hex glyphs; 0 shows them blank.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key  in  4  symbol code, sampled on the detected `flag` edge.
- flag  in  1  asynchronous push strobe; only the rising edge is used.
- clr  in  1  synchronous clear of the buffer, pulse.
- seg_out  out  8  active-low segments; bit7 = dp (always 1), bits6..0 = g..a.
- an_out  out  N_DIGITS  active-low digit enables, one-hot-low.
- fill_cnt  out  $clog2(N_DIGITS+1)  number of valid slots.

Behaviour:
- Reset, while rst=1 on a clk edge:
  - seg_out=8'hFF and an_out=all 1s.
  - All slot valid bits cleared; fill_cnt=0.
  - Scan index and divider cleared to 0.
  - Sync/edge flops cleared.
  - Reset has priority over everything, and an asserted reset mid-scan takes effect on the next edge.
- Strobe path:
  - `flag` passes through a 2-flop synchroniser, then an edge register.
  - push = sync_q & ~prev_q, a one-cycle pulse.
  - Latency: `flag` high before edge t gives push high during cycle t+2, and the buffer updates at edge t+3.
  - A level held high gives exactly one push.
  - Pulses shorter than one clk period are not guaranteed to be seen.
- Push:
  - slot[i] <= slot[i-1] for i=N_DIGITS-1..1; slot[0] <= {valid=1, key}.
  - The oldest slot is discarded when the buffer is full.
  - fill_cnt increments and saturates at N_DIGITS.
- clr:
  - All valid bits <= 0 and fill_cnt <= 0; slot data is don't-care.
  - If clr and push occur in the same cycle, clr wins and the symbol is dropped.
- Scan:
  - The divider counts 0..SCAN_DIV-1; on terminal count it wraps to 0 and the scan index advances.
  - The scan index wraps from N_DIGITS-1 to 0.
  - With SCAN_DIV=1 the index advances every cycle.
- Outputs (registered, one cycle after the scan index):
  - an_out <= ~(1<<idx).
  - seg_out <= decode(slot[idx]) if the slot is valid; otherwise 8'hFF.
- Decode table (active-low):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - With HEX_EN=1: A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - With HEX_EN=0: codes A..F give FF, but the slot still counts as valid in fill_cnt.
- A push arriving while a digit is being displayed is reflected on the segment bus from the next registered output, without waiting for a scan step.
- Index width is max(1, $clog2(N_DIGITS)); with N_DIGITS=1, an_out is constant 1'b0 after reset.

Decomposition:
- Package seg_pkg holds:
  - the active-low glyph constants (digits 0-9, hex A-F);
  - SEG_BLANK = 8'hFF;
  - the slot typedef {valid, code[3:0]}.
- Sub-module seg_digit_decode: combinational code-to-segment decoder, parameter HEX_EN, inputs {valid, code}, output 8-bit pattern.
- Synchroniser, edge detect, buffer and scan logic stay in seg_scan_display.

Test Plan (N_DIGITS=4, SCAN_DIV=4, HEX_EN=0 unless noted):
1. Reset, then idle for 32 cycles:
   - during rst, seg_out=FF and an_out=F;
   - afterwards an_out cycles E,D,B,7, each held 4 cycles, with seg_out=FF throughout and fill_cnt=0.
2. Push key=3, then key=7 (flag pulses 10 cycles wide): digit0 shows F8, digit1 shows B0, digits 2-3 show FF, fill_cnt=2.
3. Push 1,2,3,4,5: digits 0..3 show 92,99,B0,A4; the 1 is dropped; fill_cnt stays 4.
4. Push key=4'hA with HEX_EN=0: the digit shows FF and fill_cnt=1. Repeat with HEX_EN=1: the digit shows 88.
5. Hold flag high for 50 cycles: exactly one push, fill_cnt=1. Assert clr in the same cycle as a push pulse: fill_cnt=0 and all digits FF.
6. Assert rst for 1 cycle mid-scan with idx=2 and 3 slots valid: the next cycle gives seg_out=FF and an_out=F, then the scan restarts at an_out=E with the buffer empty.
